// File: rtl/mux4_rr_sequencer_if.sv
// Handshake bundle between the round-robin sequencer and its request/consumer side.
// MUX4_RR_LOCK_EN adds the burst-lock input.
interface mux4_rr_sequencer_if;
    logic [3:0] req;
    logic       ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
    logic       last;
`ifdef MUX4_RR_LOCK_EN
    logic       lock;

    modport master (output req, ready, lock, input sel, grant, valid, last);
    modport slave  (input req, ready, lock, output sel, grant, valid, last);
`else
    modport master (output req, ready, input sel, grant, valid, last);
    modport slave  (input req, ready, output sel, grant, valid, last);
`endif
endinterface

// File: rtl/mux4_rr_sequencer.sv
// Round-robin arbiter driving the select of a 4-to-1 mux, with bursts of HOLD_BEATS beats.
// Define MUX4_RR_LOCK_EN to add the lock input that holds a grant past its final beat.
module mux4_rr_sequencer #(
    parameter int unsigned HOLD_BEATS = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    mux4_rr_sequencer_if.slave   bus
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [7:0] LastBeat = 8'(HOLD_BEATS - 1);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;

    logic       accept;
    logic       drop;
    logic       done;
    logic       lock_hold;
    logic [1:0] ptr_nxt;

    // First requester at or after p, wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] k;
        logic [1:0] res;
        res = p;
        for (int i = 3; i >= 0; i--) begin
            k = p + 2'(i);
            if (r[k]) res = k;
        end
        return res;
    endfunction

`ifdef MUX4_RR_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    assign accept  = valid_q && bus.ready;
    assign drop    = !bus.req[sel_q];
    assign done    = accept && (cnt_q == LastBeat) && !lock_hold;
    assign ptr_nxt = sel_q + 2'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req != 4'b0000) begin
                    sel_d   = pick(bus.req, ptr_q);
                    cnt_d   = 8'd0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (drop || done) begin
                    ptr_d = ptr_nxt;
                    cnt_d = 8'd0;
                    if (bus.req != 4'b0000) begin
                        sel_d = pick(bus.req, ptr_nxt);
                    end else begin
                        state_d = StIdle;
                    end
                end else if (accept && (cnt_q != LastBeat)) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        valid_d = (state_d == StBusy);
        grant_d = valid_d ? (4'b0001 << sel_d) : 4'b0000;
        last_d  = valid_d && (cnt_d == LastBeat);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.sel   = sel_q;
    assign bus.grant = grant_q;
    assign bus.valid = valid_q;
    assign bus.last  = last_q;

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// Self-checking bench: directed test-plan scenarios plus a random phase against a reference model.
module tb_mux4_rr_sequencer;

    localparam int H = 4;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    // Reference model state
    int   m_busy = 0;
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   m_sel = 0;

    mux4_rr_sequencer_if bus ();

    mux4_rr_sequencer #(.HOLD_BEATS(H)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return p;
    endfunction

    // Advance the model by one edge with the currently driven inputs, then compare the DUT.
    task automatic tick();
        exp_t e;
        exp_t o;
        logic lk;
        lk = 1'b0;
`ifdef MUX4_RR_LOCK_EN
        lk = bus.lock;
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
        end else if (m_busy == 0) begin
            if (bus.req != 4'b0000) begin
                m_sel = ref_pick(bus.req, m_ptr); m_cnt = 0; m_busy = 1;
            end
        end else begin
            if (!bus.req[m_sel] || (bus.ready && m_cnt == H - 1 && !lk)) begin
                m_ptr = (m_sel + 1) % 4;
                m_cnt = 0;
                if (bus.req != 4'b0000) m_sel = ref_pick(bus.req, m_ptr);
                else m_busy = 0;
            end else if (bus.ready && m_cnt < H - 1) begin
                m_cnt++;
            end
        end
        e.sel   = 2'(m_sel);
        e.valid = (m_busy != 0);
        e.grant = e.valid ? (4'b0001 << m_sel) : 4'b0000;
        e.last  = e.valid && (m_cnt == H - 1);
        sb_q.push_back(e);
        #1;
        o = sb_q.pop_front();
        check_eq("sel", 32'(bus.sel), 32'(o.sel));
        check_eq("grant", 32'(bus.grant), 32'(o.grant));
        check_eq("valid", 32'(bus.valid), 32'(o.valid));
        check_eq("last", 32'(bus.last), 32'(o.last));
    endtask

    initial begin
        bus.req   = 4'b1111;
        bus.ready = 1'b1;
`ifdef MUX4_RR_LOCK_EN
        bus.lock  = 1'b0;
`endif
        // 1. Reset
        rst_n = 1'b0;
        tick(); tick();
        check_eq("rst_sel", 32'(bus.sel), 32'd0);
        check_eq("rst_grant", 32'(bus.grant), 32'd0);
        check_eq("rst_valid", 32'(bus.valid), 32'd0);
        check_eq("rst_last", 32'(bus.last), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("first_grant", 32'(bus.grant), 32'h1);

        // 2. Rotation with all channels requesting
        for (int i = 1; i <= 16; i++) begin
            tick();
            check_eq("rot_sel", 32'(bus.sel), 32'((i / 4) % 4));
            check_eq("rot_last", 32'(bus.last), 32'(i % 4 == 3));
            check_eq("rot_valid", 32'(bus.valid), 32'd1);
        end

        // 3. Backpressure on channel 2
        for (int i = 0; i < 8; i++) tick();
        check_eq("bp_sel", 32'(bus.sel), 32'd2);
        bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold_sel", 32'(bus.sel), 32'd2);
            check_eq("bp_hold_last", 32'(bus.last), 32'd0);
        end
        bus.ready = 1'b1;
        tick(); tick(); tick();
        check_eq("bp_last", 32'(bus.last), 32'd1);
        tick();
        check_eq("bp_rotate", 32'(bus.sel), 32'd3);

        // 4. Request drop: channel 1 then channel 3 takes over
        bus.req = 4'b0010;
        tick();
        check_eq("drop_g1", 32'(bus.sel), 32'd1);
        tick(); tick();
        bus.req = 4'b1000;
        tick();
        check_eq("drop_sel", 32'(bus.sel), 32'd3);
        check_eq("drop_grant", 32'(bus.grant), 32'h8);
        check_eq("drop_last", 32'(bus.last), 32'd0);

        // 5. Sole requester re-granted back-to-back, then idle
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("sole_sel", 32'(bus.sel), 32'd3);
            check_eq("sole_valid", 32'(bus.valid), 32'd1);
        end
        bus.req = 4'b0000;
        tick();
        check_eq("idle_valid", 32'(bus.valid), 32'd0);
        check_eq("idle_sel", 32'(bus.sel), 32'd3);
        tick();

        // 6. Reset mid-burst
        bus.req = 4'b0010;
        tick();
        check_eq("mid_g1", 32'(bus.sel), 32'd1);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_valid", 32'(bus.valid), 32'd0);
        check_eq("mid_rst_sel", 32'(bus.sel), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_grant", 32'(bus.grant), 32'h2);
        tick(); tick(); tick();
        check_eq("post_rst_last", 32'(bus.last), 32'd1);
        tick();
        check_eq("post_rst_regrant", 32'(bus.sel), 32'd1);
        check_eq("post_rst_cnt0", 32'(bus.last), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.req   = 4'($urandom_range(0, 15));
            bus.ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 40) != 0);
`ifdef MUX4_RR_LOCK_EN
            bus.lock  = ($urandom_range(0, 3) == 0);
`endif
            if ($urandom_range(0, 2) != 0) bus.req = bus.req | (4'b0001 << bus.sel);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_sequencer.md
Name: mux4_rr_sequencer

Overview:
- Upstream control stage for the 4-to-1 behavioural mux. It arbitrates four request lines round-robin and drives the mux select.
- Each grant holds for a burst of up to HOLD_BEATS accepted beats; a beat is a cycle where `valid` and `ready` are both high.
- Outputs are registered: `sel` connects straight to the mux `sel`, and `valid` qualifies the mux output `y` for the downstream consumer.

Parameters:
- HOLD_BEATS, 4, number of accepted beats per grant before forced rotation; legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req  input  4  per-channel request; bit k requests mux input ik.
- ready  input  1  downstream accepts the current beat when ready=1 and valid=1.
- sel  output  2  registered mux select; encodes the granted channel.
- grant  output  4  registered one-hot grant, equal to 1<<sel while valid=1, else 0.
- valid  output  1  registered; 1 while a channel is granted (state BUSY).
- last  output  1  1 when valid=1 and the current beat is the final beat of the burst (beat_cnt==HOLD_BEATS-1).

Behaviour:
- Internal state:
  - state: IDLE or BUSY.
  - ptr[1:0]: priority start position.
  - beat_cnt[7:0].
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, ptr=0, beat_cnt=0.
  - sel=2'b00, grant=4'b0000, valid=0, last=0.
  - Reset asserted mid-burst aborts the burst at that edge. No beat is counted on that edge.
- Arbitration function pick(r, p): the first k in order p, p+1, p+2, p+3 (mod 4) with r[k]=1. Defined only when r != 0.
- IDLE:
  - valid=0, grant=0, sel holds its previous value.
  - If req != 0, the next edge loads sel=pick(req, ptr), grant=1<<sel, valid=1, beat_cnt=0, state=BUSY.
  - Latency: req seen at edge n gives valid=1 after edge n.
  - If req == 0, stay in IDLE.
- BUSY, per edge, in priority order:
  1. Release (drop): req[sel]==0. The grant ends at this edge. If valid&&ready was also true, that beat is still accepted; the consumer owns it, and no counter effect is visible.
  2. Release (done): valid&&ready and beat_cnt==HOLD_BEATS-1.
  3. Beat: valid&&ready otherwise, so beat_cnt increments.
  4. Stall: ready=0, so sel, grant, valid and beat_cnt all hold.
- On release:
  - ptr_next=sel+1 (mod 4, 2-bit wrap 3 to 0).
  - If req != 0 at this edge: load sel=pick(req, ptr_next), beat_cnt=0, stay in BUSY with valid=1. This is back-to-back, with no idle bubble.
  - The releasing channel has the lowest priority. It is re-granted only if it is the sole requester and still asserts req.
  - Else: state=IDLE, valid=0, grant=0.
  - ptr is written with ptr_next on every release.
- Request drop while stalled (ready=0) still releases. An unaccepted beat is discarded.
- HOLD_BEATS=1: every accepted beat rotates. last=1 whenever valid=1.
- Output rules:
  - grant is always either 0 or one-hot, and matches sel.
  - sel never changes while valid=1 and ready=0, unless req[sel] drops.
- beat_cnt never exceeds HOLD_BEATS-1.

Optional Feature:
- Macro MUX4_RR_LOCK_EN.
- When defined:
  - Extra input `lock` (1 bit).
  - While valid=1 and lock=1, release (done) is suppressed and beat_cnt saturates at HOLD_BEATS-1, so last stays 1.
  - Release (drop) is still honoured.
  - lock has no effect in IDLE.
- When undefined:
  - No `lock` port.
  - Behaviour exactly as above.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with req=4'b1111 -> sel=00, grant=0000, valid=0, last=0. Release reset -> after the next edge sel=00, grant=0001, valid=1.
2. Rotation: req=4'b1111, ready=1, HOLD_BEATS=4.
   - sel sequence in 4-cycle runs: 00,01,10,11,00.
   - last=1 on the 4th beat of each run.
   - No cycle has valid=0.
3. Backpressure: grant channel 2, ready=0 for 5 cycles -> sel=10, beat_cnt frozen, valid=1. Then ready=1 -> exactly 4 beats, then rotation.
4. Request drop: channel 1 granted, req 4'b0010 -> 4'b1000 after beat 2 -> the next edge gives sel=11, grant=1000, beat_cnt=0.
5. Sole requester plus wrap: req=4'b1000 only -> channel 3 is re-granted back-to-back after each 4-beat burst with ptr wrapping to 0. Then req=0 -> IDLE, valid=0, sel stays 11.
6. Reset mid-burst (beat 2 of channel 1) -> the next edge gives the full reset state. After release with req=4'b0010 -> ptr=0 and channel 1 is granted again, starting a full 4-beat burst.
